// File: rtl/frame_buffer_arbiter.sv
// Single-port frame buffer arbiter: the display reader has priority, and the writer
// gets a forced grant after STARVE_LIMIT consecutive denied cycles.
module frame_buffer_arbiter #(
  parameter int ADDRESS_WIDTH = 15,
  parameter int DATA_WIDTH    = 8,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     read_request_in,
  input  logic [ADDRESS_WIDTH-1:0] read_address_in,
  output logic                     read_grant_out,
  output logic [DATA_WIDTH-1:0]    read_data_out,
  output logic                     read_data_out_valid,
  input  logic                     write_request_in,
  input  logic [ADDRESS_WIDTH-1:0] write_address_in,
  input  logic [DATA_WIDTH-1:0]    write_data_in,
  output logic                     write_grant_out,
  output logic [ADDRESS_WIDTH-1:0] memory_address_out,
  output logic                     memory_write_enable_out,
  output logic [DATA_WIDTH-1:0]    memory_write_data_out,
  input  logic [DATA_WIDTH-1:0]    memory_read_data_in,
  output logic [15:0]              conflict_count_out
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]               starve_q, starve_d;
  logic [15:0]              conflict_q, conflict_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     valid_q, valid_d;
  logic                     forced_s, read_grant_s, write_grant_s;

  // Grants are combinational and gated by reset so they drop the moment reset_n falls.
  always_comb begin
    forced_s      = read_request_in && write_request_in && (starve_q == STARVE_MAX);
    read_grant_s  = 1'b0;
    write_grant_s = 1'b0;
    if (!reset_n) begin
      read_grant_s  = 1'b0;
      write_grant_s = 1'b0;
    end else if (read_request_in && !forced_s) begin
      read_grant_s = 1'b1;
    end else if (write_request_in) begin
      write_grant_s = 1'b1;
    end else begin
      read_grant_s  = 1'b0;
      write_grant_s = 1'b0;
    end
  end

  // RAM-side outputs pass the winner through and otherwise hold the last driven value.
  always_comb begin
    if (read_grant_s) begin
      addr_d = read_address_in;
    end else if (write_grant_s) begin
      addr_d = write_address_in;
    end else begin
      addr_d = addr_q;
    end
    if (write_grant_s) begin
      wdata_d = write_data_in;
    end else begin
      wdata_d = wdata_q;
    end
    if (valid_q) begin
      rdata_d = memory_read_data_in;
    end else begin
      rdata_d = rdata_q;
    end
    valid_d = read_grant_s;
  end

  // Writer starvation counter and saturating conflict counter.
  always_comb begin
    if (write_grant_s) begin
      starve_d = 4'd0;
    end else if (write_request_in && (starve_q < STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
    if (read_request_in && write_request_in && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end else begin
      conflict_d = conflict_q;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_q   <= 4'd0;
      conflict_q <= 16'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      conflict_q <= conflict_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
    end
  end

  assign read_grant_out          = read_grant_s;
  assign write_grant_out         = write_grant_s;
  assign memory_address_out      = addr_d;
  assign memory_write_enable_out = write_grant_s;
  assign memory_write_data_out   = wdata_d;
  assign read_data_out_valid     = valid_q;
  assign read_data_out           = rdata_d;
  assign conflict_count_out      = conflict_q;

endmodule

// File: doc/frame_buffer_arbiter.md
FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 15, frame buffer word address width.
REQ-002 Parameter DATA_WIDTH, default 8, frame buffer word width.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive denied write-request cycles before a forced write grant; legal range 1..15.
REQ-004 clock  input  1  single clock for all logic (display pixel clock domain).
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 read_request_in  input  1  display reader requests a word.
REQ-007 read_address_in  input  ADDRESS_WIDTH  read address, valid while read_request_in is high.
REQ-008 read_grant_out  output  1  read accepted this cycle.
REQ-009 read_data_out  output  DATA_WIDTH  returned read word.
REQ-010 read_data_out_valid  output  1  read_data_out valid this cycle.
REQ-011 write_request_in  input  1  writer requests a write.
REQ-012 write_address_in  input  ADDRESS_WIDTH  write address.
REQ-013 write_data_in  input  DATA_WIDTH  write data.
REQ-014 write_grant_out  output  1  write accepted this cycle.
REQ-015 memory_address_out  output  ADDRESS_WIDTH  single-port RAM address.
REQ-016 memory_write_enable_out  output  1  RAM write strobe.
REQ-017 memory_write_data_out  output  DATA_WIDTH  RAM write data.
REQ-018 memory_read_data_in  input  DATA_WIDTH  RAM read data, one cycle after address.
REQ-019 conflict_count_out  output  16  saturating count of cycles in which both requests were high.

Function
REQ-020 Each cycle at most one of read_grant_out, write_grant_out SHALL be high.
REQ-021 Grants SHALL be combinational from current requests and starve counter; a requester holds request and address/data stable until granted.
REQ-022 Read-only request: read_grant_out=1; write-only request: write_grant_out=1; neither: no grant, memory_write_enable_out=0.
REQ-023 Both requests, starve counter < STARVE_LIMIT: read wins.
REQ-024 Both requests, starve counter == STARVE_LIMIT: write wins (forced write).
REQ-025 Starve counter (4-bit): +1 on cycles with write_request_in high and write not granted; cleared on write grant; holds when write_request_in low; never exceeds STARVE_LIMIT.
REQ-026 memory_address_out SHALL carry the granted requester's address; with no grant it SHALL hold its previous value.
REQ-027 memory_write_enable_out SHALL equal write_grant_out; memory_write_data_out SHALL equal write_data_in when granted, else hold.
REQ-028 read_data_out_valid SHALL be read_grant_out delayed one cycle; read_data_out SHALL be memory_read_data_in in that cycle, registered-through latency exactly 1 cycle from grant.
REQ-029 read_data_out SHALL hold its last valid value while read_data_out_valid is low.
REQ-030 Back-to-back reads SHALL sustain one grant per cycle; pipeline has no bubbles.
REQ-031 conflict_count_out SHALL increment once per cycle with both requests high, saturating at 16'hFFFF.
REQ-032 Forced write cycle: read_grant_out=0 and no read_data_out_valid one cycle later.

Reset
REQ-033 reset_n low SHALL asynchronously force: grants 0, read_data_out_valid 0, read_data_out 0, memory_address_out 0, memory_write_enable_out 0, memory_write_data_out 0, starve counter 0, conflict_count_out 0.
REQ-034 Read grant in the cycle before reset SHALL NOT produce read_data_out_valid after reset release.
REQ-035 First cycle after reset release SHALL arbitrate normally.

Verification
REQ-036 Single read addr 0x0010, RAM returns 0xA5 -> read_grant_out 1 at cycle N, read_data_out_valid 1 and read_data_out 0xA5 at N+1.
REQ-037 Single write addr 0x7FFF data 0x3C -> write_grant_out 1, memory_write_enable_out 1, memory_address_out 0x7FFF, memory_write_data_out 0x3C same cycle.
REQ-038 Continuous read+write requests, STARVE_LIMIT=4 -> four read grants, then one write grant, repeating; conflict_count_out increments every cycle.
REQ-039 Write requested 2 cycles then dropped, then re-raised with reads -> counter resumes from 2, forced write after 2 further denied cycles.
REQ-040 reset_n asserted mid-read-grant -> all outputs 0 immediately, no stale read_data_out_valid after release.
REQ-041 Force conflict_count_out near 0xFFFF via 65,536+ conflict cycles -> stays 0xFFFF.
